// File: rtl/music_pkg.sv
// Shared constants and types for the music playback blocks.
//   NOTE_W_DEF / DUR_W_DEF / VOICES_DEF : default widths and voice count
//   REST_NOTE                           : note code that means "rest"
//   voice_state_e                       : per-voice IDLE/BUSY tracking state
//   ptr_width()                         : index width for an N-entry pointer (min 1)
package music_pkg;

  localparam int unsigned NOTE_W_DEF = 6;
  localparam int unsigned DUR_W_DEF  = 6;
  localparam int unsigned VOICES_DEF = 3;
  localparam int unsigned REST_NOTE  = 0;

  typedef enum logic {
    V_IDLE = 1'b0,
    V_BUSY = 1'b1
  } voice_state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_allocator_picker.sv
// rr_free_picker: combinational round-robin free-slot finder.
//   idle       : 1 = slot available
//   ptr        : slot to consider first (must be < N)
//   sel_onehot : one-hot of the first idle slot scanning ptr, ptr+1, ... mod N
//   sel_idx    : binary index of that slot
//   any_free   : at least one slot is idle (sel_* are zero otherwise)
module rr_free_picker
  import music_pkg::*;
#(
  parameter int unsigned N     = VOICES_DEF,
  parameter int unsigned PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     idle,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     sel_onehot,
  output logic [PTR_W-1:0] sel_idx,
  output logic             any_free
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    any_free   = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!any_free && idle[idx]) begin
        any_free        = 1'b1;
        sel_onehot[idx] = 1'b1;
        sel_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: hands note requests from the song reader to a bank of
// note_player voices, round-robin over the idle ones.
//   clk, reset (async, active-high), flush (sync clear)
//   play        : 1 = playing, 0 = paused (gates req_ready, voice_active, rest beats)
//   beat        : one-cycle beat strobe, counts down rests
//   req_valid/req_ready/req_note/req_dur : request handshake; note 0 is a rest
//   voice_done  : per-voice done pulses, return a voice to idle
//   voice_load  : one-hot, one-cycle load pulse, one cycle after the accept
//   voice_active: per-voice play enable (busy and playing)
//   notes_to_load / durs_to_load : per-voice slices, held until the voice is reloaded
//   all_idle    : no voice busy and no rest in progress
module voice_allocator
  import music_pkg::*;
#(
  parameter int unsigned VOICES = VOICES_DEF,
  parameter int unsigned NOTE_W = NOTE_W_DEF,
  parameter int unsigned DUR_W  = DUR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       play,
  input  logic                       beat,
  input  logic                       req_valid,
  input  logic [NOTE_W-1:0]          req_note,
  input  logic [DUR_W-1:0]           req_dur,
  output logic                       req_ready,
  input  logic [VOICES-1:0]          voice_done,
  output logic [VOICES-1:0]          voice_load,
  output logic [VOICES-1:0]          voice_active,
  output logic [VOICES*NOTE_W-1:0]   notes_to_load,
  output logic [VOICES*DUR_W-1:0]    durs_to_load,
  output logic                       all_idle
);

  localparam int unsigned PTR_W = ptr_width(VOICES);

  voice_state_e              state_q [VOICES];
  voice_state_e              state_d [VOICES];
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      resting_q, resting_d;
  logic [DUR_W-1:0]          rest_cnt_q, rest_cnt_d;
  logic [VOICES-1:0]         load_q, load_d;
  logic [VOICES*NOTE_W-1:0]  notes_q, notes_d;
  logic [VOICES*DUR_W-1:0]   durs_q, durs_d;

  logic [VOICES-1:0]         busy;
  logic [VOICES-1:0]         idle;
  logic [VOICES-1:0]         sel_onehot;
  logic [PTR_W-1:0]          sel_idx;
  logic                      any_free;
  logic                      is_rest;
  logic                      accept;
  logic                      take_note;
  logic                      start_rest;

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      busy[i] = (state_q[i] == V_BUSY);
    end
  end

  // A voice whose done pulse arrives this cycle is still BUSY in state_q,
  // so it is not offered to a same-cycle accept; it frees up next cycle.
  assign idle = ~busy;

  rr_free_picker #(
    .N     (VOICES),
    .PTR_W (PTR_W)
  ) u_picker (
    .idle       (idle),
    .ptr        (ptr_q),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .any_free   (any_free)
  );

  assign is_rest    = (req_note == NOTE_W'(REST_NOTE));
  assign req_ready  = play & ~resting_q & (any_free | is_rest);
  assign accept     = req_valid & req_ready;
  assign take_note  = accept & ~is_rest & (req_dur != '0);
  assign start_rest = accept & is_rest & (req_dur != '0);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    resting_d  = resting_q;
    rest_cnt_d = rest_cnt_q;
    load_d     = '0;
    notes_d    = notes_q;
    durs_d     = durs_q;

    for (int unsigned i = 0; i < VOICES; i++) begin
      if (voice_done[i]) begin
        state_d[i] = V_IDLE;
      end
    end

    // The selected voice is idle, so a done pulse on it cannot collide here.
    if (take_note) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        if (sel_onehot[i]) begin
          state_d[i]                 = V_BUSY;
          notes_d[i*NOTE_W +: NOTE_W] = req_note;
          durs_d[i*DUR_W +: DUR_W]    = req_dur;
        end
      end
      load_d = sel_onehot;
      if (sel_idx == PTR_W'(VOICES - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = sel_idx + PTR_W'(1);
      end
    end

    // No accept is possible while resting, so the two branches never overlap.
    if (start_rest) begin
      resting_d  = 1'b1;
      rest_cnt_d = req_dur;
    end else if (resting_q && beat && play) begin
      rest_cnt_d = rest_cnt_q - DUR_W'(1);
      if (rest_cnt_q == DUR_W'(1)) begin
        resting_d = 1'b0;
      end
    end

    if (flush) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        state_d[i] = V_IDLE;
      end
      ptr_d      = '0;
      resting_d  = 1'b0;
      rest_cnt_d = '0;
      load_d     = '0;
      notes_d    = '0;
      durs_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        state_q[i] <= V_IDLE;
      end
      ptr_q      <= '0;
      resting_q  <= 1'b0;
      rest_cnt_q <= '0;
      load_q     <= '0;
      notes_q    <= '0;
      durs_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        state_q[i] <= state_d[i];
      end
      ptr_q      <= ptr_d;
      resting_q  <= resting_d;
      rest_cnt_q <= rest_cnt_d;
      load_q     <= load_d;
      notes_q    <= notes_d;
      durs_q     <= durs_d;
    end
  end

  assign voice_load    = load_q;
  assign voice_active  = busy & {VOICES{play}};
  assign notes_to_load = notes_q;
  assign durs_to_load  = durs_q;
  assign all_idle      = ~|busy & ~resting_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int V  = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            play;
  logic            beat;
  logic            req_valid;
  logic [NW-1:0]   req_note;
  logic [DW-1:0]   req_dur;
  logic            req_ready;
  logic [V-1:0]    voice_done;
  logic [V-1:0]    voice_load;
  logic [V-1:0]    voice_active;
  logic [V*NW-1:0] notes_to_load;
  logic [V*DW-1:0] durs_to_load;
  logic            all_idle;

  int checks = 0;
  int passes = 0;

  // Reference model state: rest length remaining (0 = not resting),
  // last loaded voice (-1 = none), busy flags, held slices.
  bit m_busy [V];
  int m_ptr;
  int m_rest;
  int m_load;
  int m_note [V];
  int m_dur  [V];

  voice_allocator #(
    .VOICES (V),
    .NOTE_W (NW),
    .DUR_W  (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .play          (play),
    .beat          (beat),
    .req_valid     (req_valid),
    .req_note      (req_note),
    .req_dur       (req_dur),
    .req_ready     (req_ready),
    .voice_done    (voice_done),
    .voice_load    (voice_load),
    .voice_active  (voice_active),
    .notes_to_load (notes_to_load),
    .durs_to_load  (durs_to_load),
    .all_idle      (all_idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m_busy[i] = 0;
      m_note[i] = 0;
      m_dur[i]  = 0;
    end
    m_ptr  = 0;
    m_rest = 0;
    m_load = -1;
  endtask

  function automatic bit model_ready();
    bit free;
    free = 0;
    for (int i = 0; i < V; i++) if (!m_busy[i]) free = 1;
    return play && (m_rest == 0) && (free || req_note == 0);
  endfunction

  task automatic model_step();
    bit nb [V];
    bit acc;
    int sel;
    int idx;
    if (flush) begin
      model_reset();
      return;
    end
    acc = req_valid && model_ready();
    for (int i = 0; i < V; i++) nb[i] = m_busy[i] && !voice_done[i];
    m_load = -1;
    if (acc && req_note != 0 && req_dur != 0) begin
      sel = -1;
      for (int k = 0; k < V; k++) begin
        idx = (m_ptr + k) % V;
        if (sel < 0 && !m_busy[idx]) sel = idx;
      end
      nb[sel]     = 1;
      m_ptr       = (sel + 1) % V;
      m_note[sel] = req_note;
      m_dur[sel]  = req_dur;
      m_load      = sel;
    end
    if (acc && req_note == 0 && req_dur != 0) m_rest = req_dur;
    else if (m_rest > 0 && beat && play) m_rest = m_rest - 1;
    for (int i = 0; i < V; i++) m_busy[i] = nb[i];
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    checks++; if (voice_load !== 3'b000) $display("FAIL reset_load: got %b exp 000", voice_load); else passes++;
    checks++; if (voice_active !== 3'b000) $display("FAIL reset_active: got %b exp 000", voice_active); else passes++;
    checks++; if (all_idle !== 1'b1) $display("FAIL reset_all_idle: got %b exp 1", all_idle); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", req_ready); else passes++;
    checks++; if (notes_to_load !== '0 || durs_to_load !== '0) $display("FAIL reset_slices: got %h/%h exp 0/0", notes_to_load, durs_to_load); else passes++;
    play = 0;
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready_paused: got %b exp 0", req_ready); else passes++;
    play = 1;
    #1;
  endtask

  task automatic test_fill();
    req_valid = 1; req_note = 10; req_dur = 4;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL fill_ready: got %b exp 1", req_ready); else passes++;
    tick();
    checks++; if (voice_load !== 3'b001) $display("FAIL fill_load0: got %b exp 001", voice_load); else passes++;
    req_note = 20;
    tick();
    checks++; if (voice_load !== 3'b010) $display("FAIL fill_load1: got %b exp 010", voice_load); else passes++;
    req_note = 30;
    tick();
    checks++; if (voice_load !== 3'b100) $display("FAIL fill_load2: got %b exp 100", voice_load); else passes++;
    checks++; if (notes_to_load !== {6'd30, 6'd20, 6'd10}) $display("FAIL fill_notes: got %h exp %h", notes_to_load, {6'd30, 6'd20, 6'd10}); else passes++;
    checks++; if (durs_to_load !== {6'd4, 6'd4, 6'd4}) $display("FAIL fill_durs: got %h exp %h", durs_to_load, {6'd4, 6'd4, 6'd4}); else passes++;
    req_valid = 0; req_note = 7;
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL fill_ready_full: got %b exp 0", req_ready); else passes++;
    checks++; if (voice_active !== 3'b111) $display("FAIL fill_active: got %b exp 111", voice_active); else passes++;
    checks++; if (all_idle !== 1'b0) $display("FAIL fill_all_idle: got %b exp 0", all_idle); else passes++;
  endtask

  task automatic test_done_reuse();
    voice_done = 3'b001; req_valid = 1; req_note = 9; req_dur = 3;
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL done_same_cycle_ready: got %b exp 0", req_ready); else passes++;
    tick();
    voice_done = 0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL done_next_ready: got %b exp 1", req_ready); else passes++;
    tick();
    checks++; if (voice_load !== 3'b001) $display("FAIL done_load0: got %b exp 001", voice_load); else passes++;
    req_valid = 0;
    voice_done = 3'b010;
    tick();
    voice_done = 0; req_valid = 1; req_note = 5; req_dur = 2;
    tick();
    checks++; if (voice_load !== 3'b010) $display("FAIL done_load1: got %b exp 010", voice_load); else passes++;
    checks++; if (notes_to_load !== {6'd30, 6'd5, 6'd9}) $display("FAIL done_notes: got %h exp %h", notes_to_load, {6'd30, 6'd5, 6'd9}); else passes++;
    req_valid = 0;
    voice_done = 3'b101;
    tick();
    voice_done = 0; req_valid = 1; req_note = 11; req_dur = 1;
    tick();
    checks++; if (voice_load !== 3'b100) $display("FAIL done_ptr_load2: got %b exp 100", voice_load); else passes++;
    req_note = 12; req_dur = 6;
    tick();
    checks++; if (voice_load !== 3'b001) $display("FAIL done_wrap_load0: got %b exp 001", voice_load); else passes++;
    checks++; if (durs_to_load !== {6'd1, 6'd2, 6'd6}) $display("FAIL done_durs: got %h exp %h", durs_to_load, {6'd1, 6'd2, 6'd6}); else passes++;
    req_valid = 0;
    #1;
    checks++; if (voice_active !== 3'b111) $display("FAIL done_active: got %b exp 111", voice_active); else passes++;
  endtask

  task automatic test_rest();
    req_valid = 1; req_note = 0; req_dur = 3;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL rest_ready_accept: got %b exp 1", req_ready); else passes++;
    tick();
    req_valid = 0;
    checks++; if (voice_load !== 3'b000) $display("FAIL rest_no_load: got %b exp 000", voice_load); else passes++;
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL rest_ready_start: got %b exp 0", req_ready); else passes++;
    for (int b = 0; b < 3; b++) begin
      tick();
      checks++; if (req_ready !== 1'b0) $display("FAIL rest_ready_gap%0d: got %b exp 0", b, req_ready); else passes++;
      beat = 1;
      tick();
      beat = 0;
      #1;
      checks++; if (req_ready !== (b == 2)) $display("FAIL rest_ready_beat%0d: got %b exp %b", b, req_ready, (b == 2)); else passes++;
    end
    checks++; if (voice_active !== 3'b111) $display("FAIL rest_active: got %b exp 111", voice_active); else passes++;
  endtask

  task automatic test_pause_rest();
    req_valid = 1; req_note = 0; req_dur = 3;
    tick();
    req_valid = 0;
    beat = 1;
    tick();
    beat = 0;
    play = 0;
    #1;
    checks++; if (voice_active !== 3'b000) $display("FAIL pause_active: got %b exp 000", voice_active); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL pause_ready: got %b exp 0", req_ready); else passes++;
    beat = 1; voice_done = 3'b100;
    tick();
    beat = 0; voice_done = 0;
    tick();
    beat = 1;
    tick();
    beat = 0;
    play = 1;
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL pause_rest_held: got %b exp 0", req_ready); else passes++;
    checks++; if (voice_active !== 3'b011) $display("FAIL pause_done_tracked: got %b exp 011", voice_active); else passes++;
    beat = 1;
    tick();
    beat = 0;
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL pause_second_beat: got %b exp 0", req_ready); else passes++;
    beat = 1;
    tick();
    beat = 0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL pause_third_beat: got %b exp 1", req_ready); else passes++;
    checks++; if (all_idle !== 1'b0) $display("FAIL pause_all_idle: got %b exp 0", all_idle); else passes++;
  endtask

  task automatic test_flush();
    req_valid = 1; req_note = 0; req_dur = 5;
    tick();
    req_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    #1;
    checks++; if (voice_active !== 3'b000) $display("FAIL flush_active: got %b exp 000", voice_active); else passes++;
    checks++; if (all_idle !== 1'b1) $display("FAIL flush_all_idle: got %b exp 1", all_idle); else passes++;
    checks++; if (notes_to_load !== '0 || durs_to_load !== '0) $display("FAIL flush_slices: got %h/%h exp 0/0", notes_to_load, durs_to_load); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL flush_ready: got %b exp 1", req_ready); else passes++;
    voice_done = 3'b111;
    tick();
    voice_done = 0;
    #1;
    checks++; if (all_idle !== 1'b1) $display("FAIL flush_done_idle_ignored: got %b exp 1", all_idle); else passes++;
    req_valid = 1; req_note = 13; req_dur = 0;
    tick();
    checks++; if (voice_load !== 3'b000) $display("FAIL zero_dur_no_load: got %b exp 000", voice_load); else passes++;
    req_note = 33; req_dur = 7;
    tick();
    checks++; if (voice_load !== 3'b001) $display("FAIL flush_ptr_load0: got %b exp 001", voice_load); else passes++;
    req_note = 40; req_dur = 2; flush = 1;
    tick();
    flush = 0; req_valid = 0;
    checks++; if (voice_load !== 3'b000) $display("FAIL flush_wins_load: got %b exp 000", voice_load); else passes++;
    checks++; if (voice_active !== 3'b000) $display("FAIL flush_wins_active: got %b exp 000", voice_active); else passes++;
  endtask

  task automatic test_async_reset();
    req_valid = 1; req_note = 21; req_dur = 3;
    tick();
    req_valid = 0;
    checks++; if (voice_load !== 3'b001) $display("FAIL areset_pre_load: got %b exp 001", voice_load); else passes++;
    #2 reset = 1;
    #1;
    checks++; if (voice_load !== 3'b000) $display("FAIL areset_load: got %b exp 000", voice_load); else passes++;
    checks++; if (notes_to_load !== '0) $display("FAIL areset_notes: got %h exp 0", notes_to_load); else passes++;
    checks++; if (voice_active !== 3'b000 || all_idle !== 1'b1) $display("FAIL areset_state: got %b/%b exp 000/1", voice_active, all_idle); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL areset_ready: got %b exp 1", req_ready); else passes++;
    #1 reset = 0;
  endtask

  task automatic test_random();
    logic [V-1:0] exp_load;
    logic [V-1:0] exp_active;
    bit           any_busy;
    play = 1; beat = 0; req_valid = 0; req_note = 0; req_dur = 0; voice_done = 0; flush = 0;
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      exp_load = '0;
      if (m_load >= 0) exp_load[m_load] = 1'b1;
      checks++; if (voice_load !== exp_load) $display("FAIL rnd_load c%0d: got %b exp %b", c, voice_load, exp_load); else passes++;
      for (int i = 0; i < V; i++) begin
        checks++;
        if (notes_to_load[i*NW +: NW] !== NW'(m_note[i]) || durs_to_load[i*DW +: DW] !== DW'(m_dur[i]))
          $display("FAIL rnd_slice%0d c%0d: got %0d/%0d exp %0d/%0d", i, c,
                   notes_to_load[i*NW +: NW], durs_to_load[i*DW +: DW], m_note[i], m_dur[i]);
        else passes++;
      end
      play       = ($urandom_range(0, 9) < 8);
      beat       = ($urandom_range(0, 3) == 0);
      req_valid  = ($urandom_range(0, 9) < 6);
      req_note   = ($urandom_range(0, 4) == 0) ? '0 : NW'($urandom_range(1, 63));
      req_dur    = DW'($urandom_range(0, 7));
      voice_done = ($urandom_range(0, 2) == 0) ? V'($urandom_range(0, 7)) : '0;
      flush      = ($urandom_range(0, 49) == 0);
      #1;
      exp_active = '0;
      any_busy   = 0;
      for (int i = 0; i < V; i++) begin
        exp_active[i] = m_busy[i] && play;
        if (m_busy[i]) any_busy = 1;
      end
      checks++; if (req_ready !== model_ready()) $display("FAIL rnd_ready c%0d: got %b exp %b", c, req_ready, model_ready()); else passes++;
      checks++; if (voice_active !== exp_active) $display("FAIL rnd_active c%0d: got %b exp %b", c, voice_active, exp_active); else passes++;
      checks++; if (all_idle !== (!any_busy && m_rest == 0)) $display("FAIL rnd_all_idle c%0d: got %b exp %b", c, all_idle, (!any_busy && m_rest == 0)); else passes++;
      model_step();
      tick();
    end
    flush = 0; req_valid = 0; voice_done = 0; beat = 0;
  endtask

  initial begin
    clk = 0; reset = 1; flush = 0; play = 1; beat = 0;
    req_valid = 0; req_note = 0; req_dur = 0; voice_done = 0;
    test_reset();
    test_fill();
    test_done_reuse();
    test_rest();
    test_pause_rest();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
